// File: rtl/ror_barrel_shifter.sv
// Rotate-right barrel shifter: combinational result plus a one-cycle registered
// copy with a valid flag for pipelined datapaths.
module ror_barrel_shifter #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] y_r_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] rot;

  // Log2(WIDTH) mux stages, LSB amount bit first; stage s rotates by 2^s.
  // The ternary lets an X amount bit propagate X rather than pick a branch.
  always_comb begin
    rot = a_i;
    for (int unsigned s = 0; s < AMT_W; s++) begin
      rot = amt_i[s] ? ((rot >> (2**s)) | (rot << (WIDTH - 2**s))) : rot;
    end
  end

  assign y_o = rot;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_r_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        y_r_o <= rot;
      end
    end
  end

endmodule

// File: tb/tb_ror_barrel_shifter.sv
// Directed bench for ror_barrel_shifter (WIDTH=4): combinational rotation,
// registered capture, back-to-back throughput and asynchronous reset.
module tb_ror_barrel_shifter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] a_i;
  logic [1:0] amt_i;
  logic       valid_i;
  logic [3:0] y_o;
  logic [3:0] y_r_o;
  logic       valid_o;

  int checks = 0;
  int errors = 0;

  ror_barrel_shifter #(.WIDTH(4)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_i     (a_i),
    .amt_i   (amt_i),
    .valid_i (valid_i),
    .y_o     (y_o),
    .y_r_o   (y_r_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    a_i     = 4'b0000;
    amt_i   = 2'd0;
    #1;
    checks++;
    if (y_r_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_y_r: got %b expected 0000", y_r_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", valid_o);
    end
  endtask

  task automatic test_comb_steps();
    logic [3:0] exp_tab [4];
    exp_tab = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
    a_i = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      amt_i = 2'(i);
      #10;
      checks++;
      if (y_o !== exp_tab[i]) begin
        errors++;
        $display("FAIL comb_step amt=%0d: got %b expected %b", i, y_o, exp_tab[i]);
      end
    end
  endtask

  task automatic test_wrap();
    a_i = 4'b1000; amt_i = 2'd3; #1;
    checks++;
    if (y_o !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_msb: got %b expected 0001", y_o);
    end
    a_i = 4'b0001; amt_i = 2'd1; #1;
    checks++;
    if (y_o !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_lsb: got %b expected 1000", y_o);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] exp_y;
    int         sweep_err;
    sweep_err = 0;
    for (int a = 0; a < 16; a++) begin
      for (int m = 0; m < 4; m++) begin
        a_i   = 4'(a);
        amt_i = 2'(m);
        #1;
        for (int k = 0; k < 4; k++) exp_y[k] = a_i[(k + m) % 4];
        checks++;
        if (y_o !== exp_y) begin
          errors++;
          sweep_err++;
          $display("FAIL sweep a=%b amt=%0d: got %b expected %b", a_i, m, y_o, exp_y);
        end
        if (a == 0 || a == 15) begin
          checks++;
          if (y_o !== a_i) begin
            errors++;
            $display("FAIL sweep_fixed a=%b amt=%0d: got %b expected %b", a_i, m, y_o, a_i);
          end
        end
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk_i);
    rst_ni  = 1'b1;
    valid_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b1;
    a_i     = 4'b0110;
    amt_i   = 2'd1;
    @(posedge clk_i); #1;
    checks++;
    if (y_r_o !== 4'b0011) begin
      errors++;
      $display("FAIL reg_capture: got %b expected 0011", y_r_o);
    end
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reg_valid: got %b expected 1", valid_o);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    a_i     = 4'b1111;
    @(posedge clk_i); #1;
    checks++;
    if (y_r_o !== 4'b0011) begin
      errors++;
      $display("FAIL reg_hold: got %b expected 0011", y_r_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reg_hold_valid: got %b expected 0", valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tab [3];
    exp_tab = '{4'b1101, 4'b1110, 4'b0111};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      valid_i = 1'b1;
      a_i     = 4'b1011;
      amt_i   = 2'(i + 1);
      @(posedge clk_i); #1;
      checks++;
      if (y_r_o !== exp_tab[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %b expected %b", i, y_r_o, exp_tab[i]);
      end
      checks++;
      if (valid_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: got %b expected 1", i, valid_o);
      end
    end
  endtask

  task automatic test_mid_reset();
    // valid_i still high with (1011,3) from the previous scenario
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (y_r_o !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_y_r: got %b expected 0000", y_r_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid: got %b expected 0", valid_o);
    end
    checks++;
    if (y_o !== 4'b0111) begin
      errors++;
      $display("FAIL midrst_comb: got %b expected 0111", y_o);
    end
    a_i = 4'b0100; amt_i = 2'd2; #1;
    checks++;
    if (y_o !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_comb_track: got %b expected 0001", y_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (y_r_o !== 4'b0000 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_capture: got y_r=%b valid=%b expected 0000/0", y_r_o, valid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (y_r_o !== 4'b0001 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_capture: got y_r=%b valid=%b expected 0001/1", y_r_o, valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_comb_steps();
    test_wrap();
    test_sweep();
    test_registered();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
